// File: rtl/dac_playback_reader.sv
// DAC playback reader: pulls a memory buffer over AXI4 INCR read bursts
// into a tagged sample FIFO and replays it on AXI-Stream, optionally looping.
module dac_playback_reader #(
    parameter int BURST_LEN       = 16,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         ps_clk,
    input  logic         ps_rst,
    input  logic         read_start,
    input  logic         read_stop,
    input  logic         loop_en,
    input  logic [31:0]  start_address,
    input  logic [31:0]  play_size,
    output logic [31:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [127:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         busy,
    output logic         play_done,
    output logic         rd_err,
    output logic         cfg_err,
    output logic [31:0]  current_addr,
    output logic [7:0]   loop_cycles
);

    localparam int BB  = BURST_LEN * 16;
    localparam int BBW = $clog2(BB);
    localparam int BIW = $clog2(BURST_LEN);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CW:0]   USED_MAX = (CW+1)'(FIFO_DEPTH - BURST_LEN);
    localparam logic [31:0]   BB32     = 32'(BB);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     state;
    logic           aborting;
    logic           arvalid_q;
    logic [31:0]    base_addr;
    logic [31:0]    total_bursts;
    logic [31:0]    total_beats;
    logic [31:0]    bursts_left;
    logic [31:0]    rx_cnt;
    logic [BIW-1:0] beat_idx;
    logic [OW-1:0]  outstanding;
    logic [CW-1:0]  out_beats;
    logic [CW-1:0]  fifo_count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [128:0]   mem [FIFO_DEPTH];
    logic [128:0]   head;

    logic        cfg_ok;
    logic        start_go;
    logic        stop_now;
    logic        ar_hs;
    logic        r_hs;
    logic        r_acc;
    logic        burst_end;
    logic        wr_en;
    logic        rd_en;
    logic        rx_last;
    logic        pass_end;
    logic        can_issue;
    logic        drain_done;
    logic        tvalid_int;
    logic [CW:0] used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cfg_ok = (start_address[BBW-1:0] == '0)
                 && (play_size[BBW-1:0] == '0)
                 && (play_size != 32'd0);

    assign start_go  = (state == S_IDLE) && read_start && !read_stop;
    assign stop_now  = read_stop && (state != S_IDLE) && !aborting;
    assign ar_hs     = arvalid_q && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    // beats with no burst in flight are not accounted or stored
    assign r_acc     = r_hs && (outstanding != '0);
    assign burst_end = r_acc && (&beat_idx);
    assign wr_en     = r_acc && !aborting && !stop_now;
    assign rx_last   = (rx_cnt == total_beats - 32'd1);

    assign used = {1'b0, fifo_count} + {1'b0, out_beats};

    assign can_issue = (state == S_RUN) && !stop_now && !arvalid_q
                    && (outstanding < OUT_MAX)
                    && (used <= USED_MAX)
                    && (bursts_left != 32'd0);

    assign pass_end = ar_hs && (state == S_RUN) && (bursts_left == 32'd1);

    assign drain_done = (state == S_DRAIN) && !stop_now && !arvalid_q
                     && (outstanding == '0)
                     && (aborting || (fifo_count == '0));

    assign head       = mem[rd_ptr];
    assign tvalid_int = (fifo_count != '0) && !aborting;
    assign rd_en      = tvalid_int && m_axis_tready;

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            state     <= S_IDLE;
            aborting  <= 1'b0;
            play_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        cfg_err <= !cfg_ok;
                        if (cfg_ok) begin
                            state     <= S_RUN;
                            play_done <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (stop_now) begin
                        state    <= S_DRAIN;
                        aborting <= 1'b1;
                    end else if (pass_end && !loop_en) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (stop_now) begin
                        aborting <= 1'b1;
                    end else if (drain_done) begin
                        state     <= S_IDLE;
                        aborting  <= 1'b0;
                        play_done <= !aborting;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            base_addr    <= '0;
            total_bursts <= '0;
            total_beats  <= '0;
            bursts_left  <= '0;
            current_addr <= '0;
        end else if (start_go && cfg_ok) begin
            base_addr    <= start_address;
            total_bursts <= {{BBW{1'b0}}, play_size[31:BBW]};
            total_beats  <= {4'd0, play_size[31:4]};
            bursts_left  <= {{BBW{1'b0}}, play_size[31:BBW]};
            current_addr <= start_address;
        end else if (ar_hs) begin
            if (pass_end && loop_en) begin
                current_addr <= base_addr;
                bursts_left  <= total_bursts;
            end else begin
                current_addr <= current_addr + BB32;
                bursts_left  <= bursts_left - 32'd1;
            end
        end
    end

    // AR stays up until accepted, even after an abort
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            arvalid_q <= 1'b0;
        end else begin
            arvalid_q <= (arvalid_q && !m_axi_arready) || can_issue;
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            outstanding <= '0;
            out_beats   <= '0;
            beat_idx    <= '0;
        end else begin
            outstanding <= outstanding + OW'(ar_hs) - OW'(burst_end);
            out_beats   <= out_beats
                         + (ar_hs ? CW'(BURST_LEN) : '0)
                         - CW'(r_acc);
            if (r_acc) begin
                beat_idx <= beat_idx + BIW'(1);
            end
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            rx_cnt      <= '0;
            rd_err      <= 1'b0;
            loop_cycles <= '0;
        end else if (start_go && cfg_ok) begin
            rx_cnt      <= '0;
            rd_err      <= 1'b0;
            loop_cycles <= '0;
        end else begin
            if (wr_en) begin
                rx_cnt <= rx_last ? 32'd0 : rx_cnt + 32'd1;
            end
            if ((r_hs && (m_axi_rresp != 2'b00))
                || (r_acc && (m_axi_rlast != (&beat_idx)))) begin
                rd_err <= 1'b1;
            end
            if (rd_en && head[128]) begin
                loop_cycles <= loop_cycles + 8'd1;
            end
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (stop_now) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge ps_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {rx_last, m_axi_rdata};
        end
    end

    assign m_axi_araddr  = current_addr;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state != S_IDLE);
    assign m_axis_tvalid = tvalid_int;
    assign m_axis_tdata  = head[127:0];
    assign m_axis_tlast  = tvalid_int && head[128];
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_dac_playback_reader.sv
// Bench for dac_playback_reader: random AXI slave plus a buffer-level
// model of the expected AR addresses and sample stream.
module tb_dac_playback_reader;

    localparam int BL = 16;
    localparam int BB = BL * 16;

    logic         ps_clk = 1'b0;
    logic         ps_rst = 1'b1;
    logic         read_start = 1'b0;
    logic         read_stop = 1'b0;
    logic         loop_en = 1'b0;
    logic [31:0]  start_address = '0;
    logic [31:0]  play_size = '0;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [127:0] m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = '0;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic         busy;
    logic         play_done;
    logic         rd_err;
    logic         cfg_err;
    logic [31:0]  current_addr;
    logic [7:0]   loop_cycles;

    always #5 ps_clk = ~ps_clk;

    dac_playback_reader #(
        .BURST_LEN(BL),
        .FIFO_DEPTH(64),
        .MAX_OUTSTANDING(4)
    ) dut (
        .ps_clk(ps_clk),
        .ps_rst(ps_rst),
        .read_start(read_start),
        .read_stop(read_stop),
        .loop_en(loop_en),
        .start_address(start_address),
        .play_size(play_size),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .play_done(play_done),
        .rd_err(rd_err),
        .cfg_err(cfg_err),
        .current_addr(current_addr),
        .loop_cycles(loop_cycles)
    );

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    beat_t       mon_b;
    logic [31:0] ar_log[$];
    logic [31:0] exp_ar[$];
    logic [31:0] ar_q[$];

    int n_pass = 0;
    int n_total = 0;
    int ar_cnt, r_cnt, t_cnt, cur_beat;
    int ar_pct = 100;
    int r_pct = 100;
    int err_beat = -1;
    int lasterr_beat = -1;
    int max_used, max_out, stab_err, used_now, out_now;
    bit tready_rand = 1'b0;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [128:0] prev_beat;

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        return {a, a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678};
    endfunction

    // Whole-buffer view: every pass reads base..base+size in 16-byte steps
    task automatic build_model(input logic [31:0] base,
                               input logic [31:0] size,
                               input int passes);
        beat_t b;
        for (int p = 0; p < passes; p++) begin
            for (int off = 0; off < int'(size); off += 16) begin
                b.d = beat_data(base + 32'(off));
                b.l = (off == int'(size) - 16);
                exp_q.push_back(b);
            end
            for (int off = 0; off < int'(size); off += BB) begin
                exp_ar.push_back(base + 32'(off));
            end
        end
    endtask

    function automatic int beat_diffs();
        int n = 0;
        if (got_q.size() != exp_q.size()) n++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    function automatic int ar_diffs();
        int n = 0;
        if (ar_log.size() != exp_ar.size()) n++;
        for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++) begin
            if (ar_log[i] !== exp_ar[i]) n++;
        end
        return n;
    endfunction

    always @(posedge ps_clk) begin
        if (ps_rst) begin
            ar_q.delete();
            cur_beat = 0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                ar_log.push_back(m_axi_araddr);
                ar_q.push_back(m_axi_araddr);
                ar_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready && ar_q.size() > 0) begin
                r_cnt++;
                cur_beat++;
                if (cur_beat == BL) begin
                    void'(ar_q.pop_front());
                    cur_beat = 0;
                end
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            mon_b.d = m_axis_tdata;
            mon_b.l = m_axis_tlast;
            got_q.push_back(mon_b);
            t_cnt++;
        end
        if (prev_stall && m_axis_tvalid
            && ({m_axis_tdata, m_axis_tlast} != prev_beat)) begin
            stab_err++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tlast};
        if (mon_en) begin
            used_now = ar_cnt * BL - t_cnt;
            out_now  = ar_cnt - r_cnt / BL;
            if (used_now > max_used) max_used = used_now;
            if (out_now > max_out) max_out = out_now;
        end
    end

    always @(negedge ps_clk) begin
        if (tready_rand) m_axis_tready = ($urandom_range(1) == 1);
        if (ps_rst) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
        end else begin
            m_axi_arready = (int'($urandom_range(99)) < ar_pct);
            m_axi_rvalid  = (ar_q.size() > 0)
                         && (int'($urandom_range(99)) < r_pct);
            if (ar_q.size() > 0) begin
                m_axi_rdata = beat_data(ar_q[0] + 32'(16 * cur_beat));
                m_axi_rresp = (r_cnt == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (cur_beat == BL - 1) ^ (r_cnt == lasterr_beat);
            end
        end
    end

    task automatic tick();
        @(posedge ps_clk);
        #1;
    endtask

    task automatic clear_run();
        got_q.delete();
        exp_q.delete();
        ar_log.delete();
        exp_ar.delete();
        ar_cnt = 0;
        r_cnt = 0;
        t_cnt = 0;
        err_beat = -1;
        lasterr_beat = -1;
        max_used = 0;
        max_out = 0;
        stab_err = 0;
        ar_pct = 100;
        r_pct = 100;
        tready_rand = 1'b0;
        m_axis_tready = 1'b1;
        mon_en = 1'b0;
    endtask

    task automatic start_play(input logic [31:0] a, input logic [31:0] s,
                              input logic lp);
        start_address = a;
        play_size = s;
        loop_en = lp;
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ar(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (ar_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_r(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (r_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_total++;
        if ({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast,
             busy, play_done, rd_err, cfg_err} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000",
                     {m_axi_arvalid, m_axi_rready, m_axis_tvalid,
                      m_axis_tlast, busy, play_done, rd_err, cfg_err});
        else n_pass++;
        ps_rst = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({current_addr, loop_cycles, busy, m_axi_arvalid} !== 42'd0)
            $display("FAIL reset_regs: addr %h loops %0d busy %b want 0",
                     current_addr, loop_cycles, busy);
        else n_pass++;
        n_total++;
        if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'd15, 3'b100, 2'b01})
            $display("FAIL ar_fields: got %h/%b/%b want 0f/100/01",
                     m_axi_arlen, m_axi_arsize, m_axi_arburst);
        else n_pass++;
    endtask

    task automatic test_single_pass();
        bit ok;
        clear_run();
        build_model(32'h1000_0000, 32'h400, 1);
        start_play(32'h1000_0000, 32'h400, 1'b0);
        wait_idle(3000, ok);
        n_total++;
        if (!ok) $display("FAIL single_timeout: busy still %b want 0", busy);
        else n_pass++;
        n_total++;
        if (ar_diffs() != 0)
            $display("FAIL single_ar: %0d diffs (%0d ARs) want 0 (4 ARs)",
                     ar_diffs(), ar_log.size());
        else n_pass++;
        n_total++;
        if (beat_diffs() != 0)
            $display("FAIL single_stream: %0d diffs (%0d beats) want 0 (64)",
                     beat_diffs(), got_q.size());
        else n_pass++;
        n_total++;
        if ({play_done, rd_err, loop_cycles} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL single_status: done %b err %b loops %0d want 1 0 1",
                     play_done, rd_err, loop_cycles);
        else n_pass++;
        n_total++;
        if (current_addr !== 32'h1000_0400)
            $display("FAIL single_addr: got %h want 10000400", current_addr);
        else n_pass++;
    endtask

    task automatic test_random_passes();
        bit ok;
        logic [31:0] base, size;
        for (int k = 0; k < 3; k++) begin
            clear_run();
            base = $urandom & 32'h3FFF_FF00;
            size = 32'($urandom_range(6, 1)) * 32'(BB);
            ar_pct = 60;
            r_pct = 70;
            tready_rand = 1'b1;
            build_model(base, size, 1);
            start_play(base, size, 1'b0);
            wait_idle(10000, ok);
            n_total++;
            if (!ok || ar_diffs() != 0 || beat_diffs() != 0)
                $display("FAIL rand_pass%0d: idle %b ar_diffs %0d beat_diffs %0d want 1 0 0",
                         k, ok, ar_diffs(), beat_diffs());
            else n_pass++;
            n_total++;
            if (play_done !== 1'b1 || stab_err != 0)
                $display("FAIL rand_done%0d: done %b unstable %0d want 1 0",
                         k, play_done, stab_err);
            else n_pass++;
        end
    endtask

    task automatic test_loop();
        bit ok;
        logic [31:0] base;
        clear_run();
        base = $urandom & 32'h3FFF_FF00;
        tready_rand = 1'b1;
        r_pct = 80;
        build_model(base, 32'h200, 3);
        start_play(base, 32'h200, 1'b1);
        wait_ar(5, 3000, ok);
        loop_en = 1'b0;
        n_total++;
        if (!ok) $display("FAIL loop_ar_wait: %0d ARs want 5", ar_cnt);
        else n_pass++;
        wait_idle(5000, ok);
        n_total++;
        if (!ok || ar_diffs() != 0)
            $display("FAIL loop_ar: idle %b diffs %0d (%0d ARs) want 1 0 (6)",
                     ok, ar_diffs(), ar_log.size());
        else n_pass++;
        n_total++;
        if (beat_diffs() != 0)
            $display("FAIL loop_stream: %0d diffs (%0d beats) want 0 (96)",
                     beat_diffs(), got_q.size());
        else n_pass++;
        n_total++;
        if ({loop_cycles, play_done} !== {8'd3, 1'b1})
            $display("FAIL loop_status: loops %0d done %b want 3 1",
                     loop_cycles, play_done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] base;
        clear_run();
        base = $urandom & 32'h3FFF_FF00;
        mon_en = 1'b1;
        ar_pct = 30;
        r_pct = 40;
        m_axis_tready = 1'b0;
        build_model(base, 32'h1000, 1);
        start_play(base, 32'h1000, 1'b0);
        repeat (500) tick();
        n_total++;
        if (t_cnt != 0 || max_used != 64)
            $display("FAIL bp_hold: out %0d peak %0d want 0 64", t_cnt, max_used);
        else n_pass++;
        m_axis_tready = 1'b1;
        wait_idle(20000, ok);
        n_total++;
        if (!ok || max_used > 64 || max_out > 4)
            $display("FAIL bp_credit: idle %b peak %0d outst %0d want 1 <=64 <=4",
                     ok, max_used, max_out);
        else n_pass++;
        n_total++;
        if (beat_diffs() != 0 || stab_err != 0)
            $display("FAIL bp_stream: diffs %0d unstable %0d want 0 0",
                     beat_diffs(), stab_err);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        clear_run();
        m_axis_tready = 1'b0;
        start_play(32'h2000_0000, 32'h1000, 1'b0);
        wait_ar(2, 200, ok);
        read_stop = 1'b1;
        tick();
        read_stop = 1'b0;
        n_total++;
        if (m_axis_tvalid !== 1'b0 || !ok)
            $display("FAIL abort_tvalid: tvalid %b ar_ok %b want 0 1",
                     m_axis_tvalid, ok);
        else n_pass++;
        wait_idle(2000, ok);
        n_total++;
        if (!ok || play_done !== 1'b0)
            $display("FAIL abort_end: idle %b done %b want 1 0", ok, play_done);
        else n_pass++;
        n_total++;
        if (ar_cnt != 2 || r_cnt != 32 || t_cnt != 0)
            $display("FAIL abort_count: ar %0d r %0d out %0d want 2 32 0",
                     ar_cnt, r_cnt, t_cnt);
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        bit ok;
        clear_run();
        start_play(32'h1000_0000, 32'h180, 1'b0);
        repeat (20) tick();
        n_total++;
        if ({cfg_err, busy} !== 2'b10 || ar_cnt != 0)
            $display("FAIL cfg_size: err %b busy %b ars %0d want 1 0 0",
                     cfg_err, busy, ar_cnt);
        else n_pass++;
        start_play(32'h1000_0080, 32'h400, 1'b0);
        tick();
        n_total++;
        if ({cfg_err, busy} !== 2'b10)
            $display("FAIL cfg_align: err %b busy %b want 1 0", cfg_err, busy);
        else n_pass++;
        start_address = 32'h1000_0000;
        play_size = 32'h400;
        read_start = 1'b1;
        read_stop = 1'b1;
        tick();
        read_start = 1'b0;
        read_stop = 1'b0;
        tick();
        n_total++;
        if ({cfg_err, busy} !== 2'b10)
            $display("FAIL cfg_start_stop: err %b busy %b want 1 0", cfg_err, busy);
        else n_pass++;
        build_model(32'h1000_0000, 32'h400, 1);
        start_play(32'h1000_0000, 32'h400, 1'b0);
        n_total++;
        if ({cfg_err, busy} !== 2'b01)
            $display("FAIL cfg_clear: err %b busy %b want 0 1", cfg_err, busy);
        else n_pass++;
        wait_idle(3000, ok);
        n_total++;
        if (!ok || beat_diffs() != 0)
            $display("FAIL cfg_run: idle %b diffs %0d want 1 0", ok, beat_diffs());
        else n_pass++;
    endtask

    task automatic test_resp_errors();
        bit ok;
        clear_run();
        err_beat = 5;
        build_model(32'h0400_0000, 32'h400, 1);
        start_play(32'h0400_0000, 32'h400, 1'b0);
        wait_idle(3000, ok);
        n_total++;
        if (!ok || {rd_err, play_done} !== 2'b11 || beat_diffs() != 0)
            $display("FAIL rresp_err: idle %b err %b done %b diffs %0d want 1 1 1 0",
                     ok, rd_err, play_done, beat_diffs());
        else n_pass++;
        clear_run();
        lasterr_beat = 20;
        build_model(32'h0500_0000, 32'h400, 1);
        start_play(32'h0500_0000, 32'h400, 1'b0);
        n_total++;
        if (rd_err !== 1'b0)
            $display("FAIL rderr_clear: got %b want 0", rd_err);
        else n_pass++;
        wait_idle(3000, ok);
        n_total++;
        if (!ok || {rd_err, play_done} !== 2'b11 || beat_diffs() != 0)
            $display("FAIL rlast_err: idle %b err %b done %b diffs %0d want 1 1 1 0",
                     ok, rd_err, play_done, beat_diffs());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_run();
        r_pct = 50;
        start_play(32'h0800_0000, 32'h400, 1'b1);
        wait_r(3, 500, ok);
        ps_rst = 1'b1;
        #1;
        n_total++;
        if (!ok || {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast,
                    busy, play_done, rd_err, cfg_err, current_addr,
                    loop_cycles} !== 48'd0)
            $display("FAIL reset_mid: r_ok %b flags %b addr %h loops %0d want 1 0 0 0",
                     ok, {m_axi_arvalid, m_axi_rready, m_axis_tvalid,
                          m_axis_tlast, busy, play_done, rd_err, cfg_err},
                     current_addr, loop_cycles);
        else n_pass++;
        repeat (2) tick();
        ps_rst = 1'b0;
        tick();
        clear_run();
        build_model(32'h0900_0000, 32'h400, 1);
        start_play(32'h0900_0000, 32'h400, 1'b0);
        wait_idle(3000, ok);
        n_total++;
        if (!ok || ar_diffs() != 0 || beat_diffs() != 0 || play_done !== 1'b1)
            $display("FAIL reset_restart: idle %b ar %0d beats %0d done %b want 1 0 0 1",
                     ok, ar_diffs(), beat_diffs(), play_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_random_passes();
        test_loop();
        test_backpressure();
        test_abort();
        test_cfg_err();
        test_resp_errors();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
